// File: rtl/bus_responder_pkg.sv
// Shared definitions for the bus responder: region encoding, FSM states,
// video window geometry and the address decoder.
package bus_responder_pkg;

  // Region selected by the address decoder
  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_VRAM = 2'd1,
    REG_ROM  = 2'd2,
    REG_OPEN = 2'd3
  } region_t;

  // Responder FSM states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  localparam int          VID_SIZE  = 4096;
  localparam int          VID_OFF_W = 12;
  localparam int          FIFO_W    = VID_OFF_W + 8;
  localparam logic [7:0]  OPEN_BUS  = 8'hFF;

  // Priority decode: ROM page, then video window, then RAM, else open bus.
  // Comparisons are done one bit wider so the window end cannot wrap.
  function automatic region_t decode_region(input logic [19:0] addr,
                                            input logic [19:0] vid_base,
                                            input int          ram_aw);
    logic [20:0] a;
    logic [20:0] vb;
    a  = {1'b0, addr};
    vb = {1'b0, vid_base};
    if (addr[19:16] == 4'hF) return REG_ROM;
    if ((a >= vb) && (a < vb + 21'(VID_SIZE))) return REG_VRAM;
    if (a < (21'd1 << ram_aw)) return REG_RAM;
    return REG_OPEN;
  endfunction

endpackage

// File: rtl/bus_resp_fifo.sv
// Synchronous FIFO carrying video writes to the display side.
// Extra pointer bit separates full from empty; a push while full is only
// taken when a pop happens on the same edge.
module bus_resp_fifo #(
  parameter int FIFO_AW = 3,
  parameter int W       = 20
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push,
  input  logic           pop,
  input  logic [W-1:0]   din,
  output logic [W-1:0]   dout,
  output logic           full,
  output logic           empty,
  output logic [FIFO_AW:0] count
);

  logic [W-1:0]     mem [2**FIFO_AW];
  logic [FIFO_AW:0] wr_ptr;
  logic [FIFO_AW:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[FIFO_AW-1:0]];

  // Pointer state; reset flushes the queue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Entry storage, not reset
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[FIFO_AW-1:0]] <= din;
  end

endmodule

// File: rtl/bus_responder.sv
// Memory-side responder for the 8-bit core bus: main RAM, 4 KB text-video
// window and external boot ROM, all with one-cycle read latency. Video
// writes are mirrored into a small FIFO for the display side.
// Optional feature macro RESP_CLEAR_EN: when defined, RAM and VRAM are
// zero-filled after reset while the core is held; otherwise the CLEAR
// state lasts a single cycle and no clear counter exists.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int          RAM_AW   = 16,
  parameter logic [19:0] VID_BASE = 20'hB8000,
  parameter int          FIFO_AW  = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [19:0] address,
  input  logic [7:0]  wdata,
  input  logic        wren,
  output logic [7:0]  data,
  output logic        core_hold,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_q,
  output logic        vid_valid,
  input  logic        vid_ready,
  output logic [11:0] vid_addr,
  output logic [7:0]  vid_data,
  output logic        vid_ovf
);

  state_t                state;
  state_t                state_nx;
  region_t               region_cur;
  region_t               sel_p0;
  logic [VID_OFF_W-1:0]  vid_off;
  logic                  run;

  logic [7:0]            ram [2**RAM_AW];
  logic [7:0]            vram [VID_SIZE];
  logic [7:0]            ram_q_p0;
  logic [7:0]            vram_q_p0;

  logic                  ram_we;
  logic [RAM_AW-1:0]     ram_wa;
  logic [7:0]            ram_wd;
  logic                  vram_we;
  logic [VID_OFF_W-1:0]  vram_wa;
  logic [7:0]            vram_wd;

  logic                  push_req;
  logic                  pop;
  logic                  drop;
  logic [FIFO_W-1:0]     fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_AW:0]      fifo_count;

`ifdef RESP_CLEAR_EN
  logic [RAM_AW-1:0]     clr_cnt;
`endif

  assign region_cur = decode_region(address, VID_BASE, RAM_AW);
  assign vid_off    = address[11:0] - VID_BASE[11:0];
  assign rom_addr   = address[15:0];
  assign run        = (state == ST_RUN);

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= ST_CLEAR;
    else       state <= state_nx;
  end

  // FSM next state: CLEAR ends after the last clear write, RUN is terminal
  always_comb begin
    state_nx = state;
    case (state)
`ifdef RESP_CLEAR_EN
      ST_CLEAR: if (clr_cnt == '1) state_nx = ST_RUN;
`else
      ST_CLEAR: state_nx = ST_RUN;
`endif
      default:  state_nx = ST_RUN;
    endcase
  end

  // FSM outputs: core stays held for the whole CLEAR state
  always_comb begin
    core_hold = (state == ST_CLEAR);
  end

`ifdef RESP_CLEAR_EN
  // Clear address counter, restarts from zero on every reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 clr_cnt <= '0;
    else if (state == ST_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end
`endif

  // Write-port steering: clear engine owns both memories during CLEAR
  always_comb begin
    ram_we  = run && wren && (region_cur == REG_RAM);
    ram_wa  = address[RAM_AW-1:0];
    ram_wd  = wdata;
    vram_we = run && wren && (region_cur == REG_VRAM);
    vram_wa = vid_off;
    vram_wd = wdata;
`ifdef RESP_CLEAR_EN
    if (state == ST_CLEAR) begin
      ram_we  = 1'b1;
      ram_wa  = clr_cnt;
      ram_wd  = 8'h00;
      vram_we = 1'b1;
      vram_wa = VID_OFF_W'(clr_cnt);
      vram_wd = 8'h00;
    end
`endif
  end

  // ---- stage p0: synchronous RAM, write-first on a same-address read
  always_ff @(posedge clock) begin
    if (ram_we) ram[ram_wa] <= ram_wd;
    ram_q_p0 <= (ram_we && (ram_wa == address[RAM_AW-1:0]))
                ? ram_wd : ram[address[RAM_AW-1:0]];
  end

  // ---- stage p0: synchronous VRAM, write-first on a same-offset read
  always_ff @(posedge clock) begin
    if (vram_we) vram[vram_wa] <= vram_wd;
    vram_q_p0 <= (vram_we && (vram_wa == vid_off)) ? vram_wd : vram[vid_off];
  end

  // ---- stage p0: registered region select; reads during CLEAR see open bus
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sel_p0 <= REG_OPEN;
    else       sel_p0 <= run ? region_cur : REG_OPEN;
  end

  // Read-data mux driven by the registered select
  always_comb begin
    case (sel_p0)
      REG_RAM:  data = ram_q_p0;
      REG_VRAM: data = vram_q_p0;
      REG_ROM:  data = rom_q;
      default:  data = OPEN_BUS;
    endcase
  end

  assign push_req = run && wren && (region_cur == REG_VRAM);
  assign pop      = vid_valid && vid_ready;
  assign drop     = push_req && fifo_full && !pop;

  bus_resp_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       (FIFO_W)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (push_req),
    .pop   (pop),
    .din   ({vid_off, wdata}),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign vid_valid = (fifo_count != '0);
  assign vid_addr  = fifo_empty ? 12'h000 : fifo_head[FIFO_W-1:8];
  assign vid_data  = fifo_empty ? 8'h00   : fifo_head[7:0];

  // Sticky overflow flag, set when a video write could not be queued
  always_ff @(posedge clock or posedge reset) begin
    if (reset)     vid_ovf <= 1'b0;
    else if (drop) vid_ovf <= 1'b1;
  end

endmodule

// File: tb/tb_bus_responder.sv
// Scoreboard bench for bus_responder: stimulus pushes expected read bytes
// and expected video FIFO entries; a negedge monitor pops and compares.
module tb_bus_responder;

  localparam int RAM_AW  = 13;
  localparam int CLR_CYC = 1 << RAM_AW;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] address = 20'h0;
  logic [7:0]  wdata = 8'h0;
  logic        wren = 1'b0;
  logic [7:0]  data;
  logic        core_hold;
  logic [15:0] rom_addr;
  logic [7:0]  rom_q;
  logic        vid_valid;
  logic        vid_ready = 1'b0;
  logic [11:0] vid_addr;
  logic [7:0]  vid_data;
  logic        vid_ovf;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rd_q[$];
  logic [19:0] vid_q[$];
  logic        rd_chk = 1'b0;
  logic [7:0]  e8;
  logic [19:0] e20;

  bus_responder #(
    .RAM_AW   (RAM_AW),
    .VID_BASE (20'hB8000),
    .FIFO_AW  (3)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .address   (address),
    .wdata     (wdata),
    .wren      (wren),
    .data      (data),
    .core_hold (core_hold),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q),
    .vid_valid (vid_valid),
    .vid_ready (vid_ready),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vid_ovf   (vid_ovf)
  );

  always #5 clock = ~clock;

  // External ROM: one-cycle synchronous read of a fixed pattern
  always @(posedge clock) rom_q <= rom_addr[7:0] ^ rom_addr[15:8] ^ 8'hA5;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: read data one cycle after issue, video entries on handshake
  always @(negedge clock) begin
    if (rd_chk) begin
      if (rd_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL read_data: got %0h required none (no expectation queued)", data);
      end else begin
        e8 = rd_q.pop_front();
        check("read_data", data, e8);
      end
    end
    if (vid_valid && vid_ready) begin
      if (vid_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL vid_entry: got %0h/%0h required none (no entry queued)", vid_addr, vid_data);
      end else begin
        e20 = vid_q.pop_front();
        check("vid_addr", vid_addr, e20[19:8]);
        check("vid_data", vid_data, e20[7:0]);
      end
    end
  end

  // One bus cycle; entered and left at 1 time unit after a rising edge
  task automatic cyc(input logic [19:0] a, input logic [7:0] wd, input logic we,
                     input logic rd, input logic [7:0] exp);
    address = a; wdata = wd; wren = we;
    if (rd) rd_q.push_back(exp);
    @(posedge clock); #1;
    rd_chk = rd;
    wren = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(20'h00000, 8'h00, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [19:0] a, input logic [7:0] exp);
    cyc(a, 8'h00, 1'b0, 1'b1, exp);
  endtask

  task automatic wr(input logic [19:0] a, input logic [7:0] d);
    cyc(a, d, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rd_chk = 1'b0; vid_ready = 1'b0; wren = 1'b0;
    rd_q.delete(); vid_q.delete();
    reset = 1'b1;
    #1;
    check("rst_core_hold", core_hold, 1);
    check("rst_data", data, 8'hFF);
    check("rst_vid_valid", vid_valid, 0);
    check("rst_vid_addr", vid_addr, 0);
    check("rst_vid_data", vid_data, 0);
    check("rst_vid_ovf", vid_ovf, 0);
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Count edges after release for which core_hold stays high
  task automatic wait_clear();
    int n;
    n = 0;
    while (core_hold && n < CLR_CYC + 16) begin
      idle(1);
      n++;
    end
`ifdef RESP_CLEAR_EN
    check("clear_cycles", n, CLR_CYC);
`else
    check("clear_cycles", n, 1);
`endif
    check("hold_released", core_hold, 0);
  endtask

  task automatic vwr(input logic [11:0] off, input logic [7:0] d, input logic queued);
    if (queued) vid_q.push_back({off, d});
    wr(20'hB8000 + {8'h00, off}, d);
  endtask

  task automatic drain(input int n);
    vid_ready = 1'b1;
    idle(n);
    vid_ready = 1'b0;
    check("vid_drained", vid_valid, 0);
    check("vid_q_left", vid_q.size(), 0);
  endtask

  initial begin
    do_reset();
    wait_clear();
`ifdef RESP_CLEAR_EN
    rd(20'h01234, 8'h00);
`endif
    // RAM write then read, and a same-cycle write/read
    wr(20'h00100, 8'h5A);
    rd(20'h00100, 8'h5A);
    cyc(20'h00101, 8'h33, 1'b1, 1'b1, 8'h33);
    rd(20'h00101, 8'h33);
    // ROM writes are ignored and must not alias into RAM
    wr(20'h00010, 8'h11);
    wr(20'hF0010, 8'h77);
    rd(20'hF0010, 8'hB5);
    rd(20'h00010, 8'h11);
    // Open bus reads 0xFF and writes do not alias
    wr(20'h00000, 8'h22);
    wr(20'h70000, 8'h99);
    rd(20'h70000, 8'hFF);
    rd(20'h00000, 8'h22);
    // Single video write, visible at the FIFO head
    vwr(12'h002, 8'h41, 1'b1);
    check("vid_valid_1", vid_valid, 1);
    check("vid_head_addr", vid_addr, 12'h002);
    check("vid_head_data", vid_data, 8'h41);
    rd(20'hB8002, 8'h41);
    drain(1);
    // Nine writes with the consumer stalled: ninth dropped
    for (int i = 0; i < 9; i++) begin
      vwr(12'h010 + 12'(i), 8'h80 + 8'(i), i < 8);
      if (i == 7) check("ovf_after_8", vid_ovf, 0);
    end
    check("ovf_after_9", vid_ovf, 1);
    for (int i = 0; i < 9; i++) rd(20'hB8010 + 20'(i), 8'h80 + 8'(i));
    drain(8);
    check("ovf_sticky", vid_ovf, 1);
    // Reset in RUN flushes the FIFO and the flag
    do_reset();
    wait_clear();
    // Full FIFO with a simultaneous push and pop
    for (int i = 0; i < 8; i++) vwr(12'h020 + 12'(i), 8'hC0 + 8'(i), 1'b1);
    vid_ready = 1'b1;
    vwr(12'h028, 8'hC8, 1'b1);
    vid_ready = 1'b0;
    check("ovf_full_pop", vid_ovf, 0);
    vwr(12'h029, 8'hC9, 1'b0);
    check("ovf_still_full", vid_ovf, 1);
    drain(8);
`ifdef RESP_CLEAR_EN
    // Reset part way through CLEAR restarts the fill
    do_reset();
    idle(99);
    rd(20'h00010, 8'hFF);
    check("hold_mid_clear", core_hold, 1);
    do_reset();
    wait_clear();
    rd(20'h70000, 8'hFF);
    rd(20'h00100, 8'h00);
    rd(20'hB8002, 8'h00);
    rd(20'h01234, 8'h00);
`endif
    idle(2);
    check("rd_q_left", rd_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
